if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the RISC-V core. Sits directly upstream of `i_mem`: drives its read address, captures the returned instruction word, and hands {pc, instr} pairs to decode through a valid/ready handshake. Holds the program counter, sequences PC+4 fetches, absorbs decode back-pressure in a small buffer, and handles redirects (branch/jump) with flush of stale fetches.

## Interface
Parameters:
- `XLEN`, 32, address/data width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 2, output buffer entries (power of two, ≥2)

Ports:
- `clk`  in  1  core clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset (0 = reset)
- `imem_addr`  out  XLEN  byte address to `i_mem` `rd_addr0`
- `imem_rdata`  in  XLEN  instruction word from `i_mem` `rd_dout0`
- `redirect_valid`  in  1  load new PC this cycle
- `redirect_pc`  in  XLEN  redirect target, bits [1:0] ignored
- `out_valid`  out  1  {out_pc, out_instr} valid to decode
- `out_ready`  in  1  decode accepts this cycle
- `out_pc`  out  XLEN  PC of presented instruction
- `out_instr`  out  XLEN  presented instruction word

## Operation
- `i_mem` read is synchronous, 1-cycle: address sampled at edge E, data valid during the cycle after E. No request signal; `imem_addr` is sampled every edge; a fetch is "issued" only when `issue` is high internally.
- `imem_addr` = `pc_q` (combinational). `pc_q` is word-aligned; bits [1:0] always 0.
- issue = !redirect_valid && (count + inflight − pop) < DEPTH, where pop = out_valid && out_ready and inflight ∈ {0,1}.
- On issue: `pc_q <= pc_q + 4` (mod 2^XLEN; 32'hFFFF_FFFC wraps to 0); inflight <= 1, `infl_pc <= pc_q`. No issue: inflight <= 0, `pc_q` held.
- Response: if inflight was 1 and not killed, push {infl_pc, imem_rdata} into FIFO.
- FIFO: DEPTH entries, in-order; head drives out_pc/out_instr; out_valid = (count != 0). Simultaneous push and pop allowed, count unchanged.
- Redirect (highest priority): `pc_q <= {redirect_pc[XLEN-1:2], 2'b00}`; FIFO flushed (count <= 0); in-flight response dropped; no issue that cycle; pop ignored even if out_ready high.
- FSM (2 states): BOOT (in reset and first cycle after release; no issue) → RUN (unconditional after one cycle). Redirect in BOOT is honoured.
- Handshake: once out_valid=1, out_pc/out_instr stay stable until pop or redirect.

## Timing
- Reset values: `pc_q`=RESET_PC, `imem_addr`=RESET_PC, out_valid=0, out_pc=0, out_instr=0, count=0, inflight=0, state=BOOT.
- Reset is asynchronous assert, synchronous-effect deassert; reset mid-stream discards FIFO and in-flight fetch.
- After rst release: cycle 0 BOOT, cycle 1 first issue (RESET_PC), out_valid=1 in cycle 3.
- Fetch-to-out_valid latency: 2 cycles from issue.
- Redirect at edge R: target issued cycle R+1, out_valid in cycle R+3.
- Sustained throughput 1 instr/cycle with out_ready held high.
- Back-pressure: with out_ready low, issue stops once count+inflight=DEPTH; no fetch is ever dropped or duplicated.

## Structure
- Shared `core_pkg`: `XLEN`, `RESET_PC` default, `ILEN`, PC increment constant, `fetch_pkt_t` {pc, instr} struct.
- One sub-module: `fetch_fifo` (parameterised DEPTH, push/pop/flush, count output). FSM, PC and issue logic stay in `if_stage`.

## Test plan
- Reset/startup: i_mem preloaded word[k]=k+0x100, out_ready=1 → out_valid first high 3 cycles after release, pairs (0,0x100),(4,0x101),(8,0x102)… one per cycle.
- Back-pressure: out_ready=0 for 10 cycles after first valid → out_pc stays 0, imem_addr stops at 0x8; resume → sequence continues 0x4, 0x8 with no gap or duplicate.
- Redirect: redirect_valid with redirect_pc=0x43 while FIFO holds 2 entries → FIFO flushed, next out_pc=0x40 with word[16], 3 cycles later.
- Redirect with simultaneous pop and in-flight response → popped entry not consumed twice; stale response never appears on out_instr.
- Wrap: redirect_pc=32'hFFFF_FFF8 → out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Async reset asserted mid-stream (out_valid=1) → out_valid=0, out_pc=0, imem_addr=RESET_PC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, reset PC, and the fetch packet
// that travels from fetch to decode.
package core_pkg;
  localparam int          CORE_XLEN     = 32;
  localparam int          ILEN          = 32;
  localparam logic [31:0] CORE_RESET_PC = 32'h0000_0000;
  localparam int          PC_INC        = 4;

  typedef struct packed {
    logic [CORE_XLEN-1:0] pc;
    logic [ILEN-1:0]      instr;
  } fetch_pkt_t;

  typedef enum logic {BOOT, RUN} fetch_state_e;
endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: i_mem read port, redirect input, and the decode handshake.
interface if_stage_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;

  modport master (
    output imem_addr, out_valid, out_pc, out_instr,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input  imem_addr, out_valid, out_pc, out_instr,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// In-order buffer of fetched {pc, instr} packets between i_mem and decode.
module fetch_fifo import core_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  fetch_pkt_t                 pkt_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output fetch_pkt_t                 head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  fetch_pkt_t    mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage needs no reset: the top masks the head while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= pkt_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC sequencing, one-deep i_mem pipeline, redirect flush,
// and a small buffer that absorbs decode back-pressure.
module if_stage import core_pkg::*; #(
  parameter int              XLEN     = CORE_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = CORE_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic      clk,
  input  logic      rst,
  if_stage_if.master bus
);
  localparam int CW = $clog2(DEPTH+1);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            infl_q, infl_d;
  logic [XLEN-1:0] infl_pc_q, infl_pc_d;

  logic            issue, push, pop, pop_raw, out_valid;
  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  fetch_pkt_t      head, pkt_in;

  assign out_valid = (count != '0);
  assign pop_raw   = out_valid && bus.out_ready;
  // A redirect discards the buffer, so nothing is consumed in that cycle.
  assign pop       = pop_raw && !bus.redirect_valid;
  assign push      = infl_q && !bus.redirect_valid;

  // Slots that will be occupied next cycle before this cycle's issue.
  assign occ   = {1'b0, count} + (CW+1)'(infl_q) - (CW+1)'(pop_raw);
  assign issue = (state_q == RUN) && !bus.redirect_valid && (occ < (CW+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      infl_q    <= infl_d;
      infl_pc_q <= infl_pc_d;
    end
  end

  always_comb begin
    state_d   = RUN;
    pc_d      = pc_q;
    infl_d    = issue;
    infl_pc_d = infl_pc_q;
    if (bus.redirect_valid) begin
      pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
    end else if (issue) begin
      pc_d      = pc_q + XLEN'(PC_INC);
      infl_pc_d = pc_q;
    end
  end

  assign pkt_in.pc    = infl_pc_q;
  assign pkt_in.instr = bus.imem_rdata;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pkt_i   (pkt_in),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .head_o  (head),
    .count_o (count)
  );

  assign bus.imem_addr = pc_q;
  assign bus.out_valid = out_valid;
  assign bus.out_pc    = out_valid ? head.pc    : '0;
  assign bus.out_instr = out_valid ? head.instr : '0;
endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: expected {pc, instr} pairs are queued by the
// stimulus and checked by a monitor on every accepted handshake.
module tb_if_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  if_stage_if #(.XLEN(32)) bus ();

  if_stage #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } pair_t;

  pair_t exp_q [$];
  int total = 0;
  int bad   = 0;

  // i_mem contents: word[k] = k + 0x100 at every address.
  function automatic logic [31:0] word_at(logic [31:0] a);
    return (a >> 2) + 32'h100;
  endfunction

  always @(posedge clk) bus.imem_rdata <= word_at(bus.imem_addr);

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    pair_t e;
    if (rst && bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got pc %h expected no output", bus.out_pc);
      end else begin
        e = exp_q.pop_front();
        chk("out_pc", bus.out_pc, e.pc);
        chk("out_instr", bus.out_instr, e.instr);
      end
    end
  end

  task automatic push_seq(logic [31:0] start, int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = start + 32'(4 * i);
      exp_q.push_back('{pc: a, instr: word_at(a)});
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Count edges until out_valid rises, starting from n0 edges already seen.
  task automatic wait_valid(string nm, int n0, int exp_n);
    int n;
    n = n0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, 32'(n), 32'(exp_n));
  endtask

  task automatic redirect_to(logic [31:0] tgt);
    bus.redirect_pc    = tgt;
    bus.redirect_valid = 1'b1;
    exp_q.delete();
    push_seq({tgt[31:2], 2'b00}, 16);
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    chk("redirect_flush", 32'(bus.out_valid), 32'd0);
    wait_valid("redirect_latency", 1, 3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b1;
    #2;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_pc",    bus.out_pc,    32'h0);
    chk("reset_out_instr", bus.out_instr, 32'h0);
    chk("reset_imem_addr", bus.imem_addr, 32'h0);

    // Startup with decode always ready.
    push_seq(32'h0, 32);
    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_valid("startup_latency", 0, 3);
    cyc(6);

    // Redirect while a pop and an in-flight fetch coincide.
    redirect_to(32'h200);
    cyc(4);

    // Fill the buffer, then redirect to an unaligned target.
    bus.out_ready = 1'b0;
    cyc(4);
    chk("full_out_valid", 32'(bus.out_valid), 32'd1);
    redirect_to(32'h43);
    chk("redir_head_pc",    bus.out_pc,    32'h40);
    chk("redir_head_instr", bus.out_instr, 32'h110);
    bus.out_ready = 1'b1;
    cyc(4);

    // Address wrap past the top of the space.
    redirect_to(32'hFFFF_FFF8);
    cyc(5);

    // Asynchronous reset in the middle of a stream.
    chk("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("async_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_out_pc",    bus.out_pc,    32'h0);
    chk("async_imem_addr", bus.imem_addr, 32'h0);

    // Back-pressure from startup: decode stalls for 10 cycles, then resumes.
    bus.out_ready = 1'b0;
    push_seq(32'h0, 32);
    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_valid("bp_latency", 0, 3);
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_pc",    bus.out_pc,    32'h0);
      chk("bp_imem_addr", bus.imem_addr, 32'h8);
      cyc(1);
    end
    bus.out_ready = 1'b1;
    cyc(8);
    bus.out_ready = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
